crack_scheduler: RTL and testbench
==================================

// Module: crack_scheduler
// PURPOSE
//  Top-level sequencer for an N-engine parallel ARC4 key search. Launches all crack engines
//  together, round-robin shares the single ct_mem read port between them, and collects
//  the first valid key. Reports a no-key result once every engine finishes without a match.
//  Sits between the task-level en/rdy handshake and the per-engine crack instances.
// PARAMETERS
//  N_ENG    4   number of crack engines (2..8); engine i searches keys i, i+N_ENG, ...
//  KEY_W    24  key width
// PORTS
//  clk            in   1          system clock
//  rst_n          in   1          reset; one clock, synchronous, active-low
//  en             in   1          start request; accepted only while rdy=1
//  rdy            out  1          idle / result available
//  key            out  KEY_W      winning key (0 when none)
//  key_valid      out  1          key holds a found key
//  winner         out  3          index of winning engine
//  ct_addr        out  8          shared ciphertext memory address
//  ct_rddata      in   8          ct_mem data, valid 1 cycle after ct_addr
//  eng_start      out  N_ENG      one-cycle start pulse per engine
//  eng_rdy        in   N_ENG      engine idle/done
//  eng_key        in   N_ENG*KEY_W engine i key at [i*KEY_W +: KEY_W]
//  eng_key_valid  in   N_ENG      engine found key (meaningful while eng_rdy)
//  eng_ct_req     in   N_ENG      engine requests a ct read; held until granted
//  eng_ct_addr    in   N_ENG*8    requested address
//  eng_ct_gnt     out  N_ENG      one-hot grant, same cycle as ct_addr
//  eng_ct_rdvalid out  N_ENG      one-hot, 1 cycle after grant; data = eng_ct_rddata
//  eng_ct_rddata  out  8          broadcast copy of ct_rddata
// BEHAVIOUR
//  Reset (sync, rst_n=0 at posedge): state IDLE; rdy=1, key=0, key_valid=0, winner=0,
//   eng_start=0, eng_ct_gnt=0, eng_ct_rdvalid=0, ct_addr=0, RR pointer=0, done mask=0.
//   Reset mid-search abandons the search; no grant or rdvalid issued after reset edge.
//  States: IDLE -> (en) ARM -> LAUNCH -> SETTLE -> RUN -> DONE_KEY | DONE_NOKEY.
//   IDLE: rdy=1. en=1 -> ARM; key/key_valid/winner cleared on this transition.
//   ARM: rdy=0; wait until &eng_rdy, then LAUNCH.
//   LAUNCH: eng_start = all ones for exactly this cycle -> SETTLE.
//   SETTLE: one cycle, eng_rdy ignored (engines drop rdy here) -> RUN; done mask=0.
//   RUN: done_mask |= eng_rdy. Any i with eng_rdy[i]&eng_key_valid[i] -> DONE_KEY;
//    lowest such index wins; key<=eng_key[i], winner<=i, key_valid<=1 next cycle.
//    Else if done_mask|eng_rdy is all ones -> DONE_NOKEY (key=0, key_valid=0).
//   DONE_KEY / DONE_NOKEY: rdy=1, outputs held; en=1 -> ARM (new search).
//  en while rdy=0 ignored. Outputs registered; rdy rises the cycle key_valid does.
//  Arbitration (RUN only; grants 0 in all other states):
//   - one grant per cycle, round-robin; search starts at ptr; after grant to g ptr<=g+1 mod N_ENG.
//   - ct_addr = eng_ct_addr[g] combinationally when granted, else holds last value.
//   - eng_ct_rdvalid[g] registered, high cycle after grant; eng_ct_rddata = ct_rddata.
//   - grant in last RUN cycle still produces its rdvalid in the following cycle.
//   - no requests: no grant, ptr unchanged. Single requester gets a grant every cycle.
// STRUCTURE
//  crack_pkg: KEY_W, sched_state_e enum (IDLE, ARM, LAUNCH, SETTLE, RUN, DONE_KEY, DONE_NOKEY),
//   N_ENG default.
//  Sub-module rr_arbiter #(N): req, advance -> one-hot gnt, index; owns the pointer.
//  Winner select is a lowest-index priority encoder inside crack_scheduler.
// TESTING
//  1 Reset then en=1, all eng_rdy=1 -> eng_start=4'b1111 exactly once, 3 cycles after en.
//  2 eng 2 rdy with key_valid, key 24'h00_1A2B, eng 0 still busy -> key=24'h001A2B, winner=2, rdy=1.
//  3 engines 1 and 3 valid same cycle -> winner=1; later eng 3 result ignored.
//  4 All four finish, none valid -> DONE_NOKEY, key=0, key_valid=0, rdy=1.
//  5 eng_ct_req=4'b1111 held 8 cycles -> grants 0,1,2,3,0,1,2,3; rdvalid follows 1 cycle later
//   with ct_rddata copied; ct_addr matches granted engine's address.
//  6 rst_n=0 for one edge mid-RUN with requests pending -> IDLE, rdy=1, no grants/rdvalid after.

Source files
------------

// File: rtl/crack_scheduler_pkg.sv
// Shared types and defaults for the parallel ARC4 key-search scheduler.
// Engine count, key width and the scheduler state encoding live here.
package crack_scheduler_pkg;

    localparam int N_ENG_DEF = 4;
    localparam int KEY_W     = 24;
    localparam int CT_AW     = 8;
    localparam int CT_DW     = 8;
    localparam int WIN_W     = 3;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        LAUNCH,
        SETTLE,
        RUN,
        DONE_KEY,
        DONE_NOKEY
    } sched_state_e;

    // States in which a new search request may be accepted.
    function automatic logic accepts_start(sched_state_e s);
        return (s == IDLE) || (s == DONE_KEY) || (s == DONE_NOKEY);
    endfunction

endpackage

// File: rtl/crack_scheduler_if.sv
// Task-side handshake, ct_mem port and per-engine bundle of the key-search scheduler.
// slave = scheduler side, master = surrounding task logic, memory and engines.
interface crack_scheduler_if #(
    parameter int N_ENG = 4,
    parameter int KEY_W = 24
);
    logic                    en;
    logic                    rdy;
    logic [KEY_W-1:0]        key;
    logic                    key_valid;
    logic [2:0]              winner;
    logic [7:0]              ct_addr;
    logic [7:0]              ct_rddata;
    logic [N_ENG-1:0]        eng_start;
    logic [N_ENG-1:0]        eng_rdy;
    logic [N_ENG*KEY_W-1:0]  eng_key;
    logic [N_ENG-1:0]        eng_key_valid;
    logic [N_ENG-1:0]        eng_ct_req;
    logic [N_ENG*8-1:0]      eng_ct_addr;
    logic [N_ENG-1:0]        eng_ct_gnt;
    logic [N_ENG-1:0]        eng_ct_rdvalid;
    logic [7:0]              eng_ct_rddata;

    modport slave (
        input  en, ct_rddata, eng_rdy, eng_key, eng_key_valid, eng_ct_req, eng_ct_addr,
        output rdy, key, key_valid, winner, ct_addr, eng_start, eng_ct_gnt,
               eng_ct_rdvalid, eng_ct_rddata
    );

    modport master (
        output en, ct_rddata, eng_rdy, eng_key, eng_key_valid, eng_ct_req, eng_ct_addr,
        input  rdy, key, key_valid, winner, ct_addr, eng_start, eng_ct_gnt,
               eng_ct_rdvalid, eng_ct_rddata
    );

endinterface

// File: rtl/crack_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
// Grant is combinational; the pointer moves past the winner only when advance is set.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         i_req,
    input  logic                 i_advance,
    output logic [N-1:0]         o_gnt,
    output logic [$clog2(N)-1:0] o_idx,
    output logic                 o_vld
);
    localparam int IW = $clog2(N);

    logic [IW-1:0] r_ptr;
    logic [N-1:0]  w_gnt;
    logic [IW-1:0] w_idx;
    logic          w_vld;

    always_comb begin
        int cand;
        w_gnt = '0;
        w_idx = '0;
        w_vld = 1'b0;
        cand  = 0;
        for (int k = 0; k < N; k++) begin
            cand = int'(r_ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!w_vld && i_req[cand]) begin
                w_vld       = 1'b1;
                w_gnt[cand] = 1'b1;
                w_idx       = IW'(cand);
            end
        end
    end

    // With no requests the pointer stays put, so fairness survives idle gaps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_advance && w_vld) begin
            r_ptr <= (w_idx == IW'(N - 1)) ? '0 : w_idx + IW'(1);
        end
    end

    assign o_gnt = w_gnt;
    assign o_idx = w_idx;
    assign o_vld = w_vld;

endmodule

// File: rtl/crack_scheduler.sv
// Sequencer for N parallel ARC4 crack engines: launches all, shares ct_mem round-robin,
// returns the lowest-index winning key or a no-key result once every engine has finished.
module crack_scheduler
    import crack_scheduler_pkg::*;
#(
    parameter int N_ENG = N_ENG_DEF,
    parameter int KW    = KEY_W
) (
    input  logic             clk,
    input  logic             rst_n,
    crack_scheduler_if.slave bus
);
    localparam int IW = $clog2(N_ENG);

    sched_state_e     r_state;
    sched_state_e     w_next;

    logic             r_rdy;
    logic [KW-1:0]    r_key;
    logic             r_key_valid;
    logic [WIN_W-1:0] r_winner;
    logic [N_ENG-1:0] r_eng_start;
    logic [N_ENG-1:0] r_rdvalid;
    logic [7:0]       r_ct_addr;
    logic [N_ENG-1:0] r_done_mask;

    logic             w_accept;
    logic             w_hit;
    logic [IW-1:0]    w_hit_idx;
    logic [KW-1:0]    w_hit_key;
    logic             w_all_done;
    logic             w_in_run;
    logic [N_ENG-1:0] w_arb_req;
    logic [N_ENG-1:0] w_gnt;
    logic [IW-1:0]    w_gnt_idx;
    logic             w_gnt_vld;
    logic [7:0]       w_gnt_addr;

    assign w_in_run  = (r_state == RUN);
    assign w_accept  = accepts_start(r_state) && bus.en;
    assign w_arb_req = w_in_run ? bus.eng_ct_req : '0;

    rr_arbiter #(.N(N_ENG)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (w_arb_req),
        .i_advance (w_in_run),
        .o_gnt     (w_gnt),
        .o_idx     (w_gnt_idx),
        .o_vld     (w_gnt_vld)
    );

    // Lowest index wins when several engines report a key in the same cycle.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = N_ENG - 1; i >= 0; i--) begin
            if (bus.eng_rdy[i] && bus.eng_key_valid[i]) begin
                w_hit     = 1'b1;
                w_hit_idx = IW'(i);
            end
        end
    end

    assign w_hit_key  = bus.eng_key[w_hit_idx*KW +: KW];
    assign w_all_done = &(r_done_mask | bus.eng_rdy);
    assign w_gnt_addr = bus.eng_ct_addr[w_gnt_idx*8 +: 8];

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE_KEY, DONE_NOKEY: begin
                if (bus.en) w_next = ARM;
            end
            ARM: begin
                if (&bus.eng_rdy) w_next = LAUNCH;
            end
            LAUNCH:  w_next = SETTLE;
            SETTLE:  w_next = RUN;
            RUN: begin
                if (w_hit) begin
                    w_next = DONE_KEY;
                end else if (w_all_done) begin
                    w_next = DONE_NOKEY;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Engines are still dropping rdy during SETTLE, so the mask only starts in RUN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_done_mask <= '0;
        end else if (r_state == SETTLE) begin
            r_done_mask <= '0;
        end else if (w_in_run) begin
            r_done_mask <= r_done_mask | bus.eng_rdy;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdy       <= 1'b1;
            r_key       <= '0;
            r_key_valid <= 1'b0;
            r_winner    <= '0;
            r_eng_start <= '0;
        end else begin
            r_rdy       <= accepts_start(w_next);
            r_eng_start <= (w_next == LAUNCH) ? '1 : '0;
            if (w_accept) begin
                r_key       <= '0;
                r_key_valid <= 1'b0;
                r_winner    <= '0;
            end else if (w_in_run && w_hit) begin
                r_key       <= w_hit_key;
                r_key_valid <= 1'b1;
                r_winner    <= WIN_W'(w_hit_idx);
            end else if (w_in_run && w_all_done) begin
                r_key       <= '0;
                r_key_valid <= 1'b0;
            end
        end
    end

    // A grant in the final RUN cycle still returns its read data on the next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdvalid <= '0;
            r_ct_addr <= '0;
        end else begin
            r_rdvalid <= w_gnt;
            if (w_gnt_vld) begin
                r_ct_addr <= w_gnt_addr;
            end
        end
    end

    assign bus.rdy            = r_rdy;
    assign bus.key            = r_key;
    assign bus.key_valid      = r_key_valid;
    assign bus.winner         = r_winner;
    assign bus.eng_start      = r_eng_start;
    assign bus.eng_ct_gnt     = w_gnt;
    assign bus.ct_addr        = w_gnt_vld ? w_gnt_addr : r_ct_addr;
    assign bus.eng_ct_rdvalid = r_rdvalid;
    assign bus.eng_ct_rddata  = bus.ct_rddata;

endmodule

// File: tb/tb_crack_scheduler.sv
// Self-checking bench for crack_scheduler: launch timing, key selection, no-key
// completion, round-robin ct_mem sharing via a grant/readback scoreboard, and reset abort.
module tb_crack_scheduler;
    import crack_scheduler_pkg::*;

    localparam int N  = 4;
    localparam int KW = 24;

    typedef struct {
        int         idx;
        logic [7:0] dat;
    } rd_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    crack_scheduler_if #(.N_ENG(N), .KEY_W(KW)) bus ();

    crack_scheduler #(.N_ENG(N), .KW(KW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int  n_chk = 0;
    int  n_err = 0;
    int  exp_gnt[$];
    rd_t exp_rd[$];

    function automatic logic [7:0] mem_f(logic [7:0] a);
        return {a[3:0], a[7:4]} ^ 8'h3C;
    endfunction

    function automatic logic [7:0] eng_addr(int i);
        return 8'(8'h40 + 8'h11 * i);
    endfunction

    // ct_mem model: read data one cycle after the address.
    always @(posedge clk) bus.ct_rddata <= mem_f(bus.ct_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Starts a search at the current negedge; returns at the first RUN-cycle negedge.
    // launch_cyc counts the en cycle as cycle 1.
    task automatic start_search(output int launch_cyc, output int n_starts);
        launch_cyc        = 0;
        n_starts          = 0;
        bus.eng_rdy       = '1;
        bus.eng_key_valid = '0;
        bus.en            = 1'b1;
        for (int c = 2; c <= 14; c++) begin
            @(negedge clk);
            bus.en = 1'b0;
            if (c == 2) begin
                check("arm_rdy", bus.rdy, 0);
                check("arm_keyvalid_clr", bus.key_valid, 0);
            end
            if (bus.eng_start !== '0) begin
                n_starts++;
                if (launch_cyc == 0 && bus.eng_start === 4'hF) begin
                    launch_cyc  = c;
                    bus.eng_rdy = '0;
                end
            end
            if (launch_cyc != 0 && c == launch_cyc + 2) break;
        end
        if (launch_cyc == 0) check("launch_timeout", 0, 1);
    endtask

    // Pops n expected grants; each grant's readback is checked the following cycle.
    task automatic run_grants(input int n);
        int  idx;
        rd_t r;
        for (int k = 0; k < n; k++) begin
            #1;
            idx = exp_gnt.pop_front();
            check("gnt", 32'(bus.eng_ct_gnt), 32'(1) << idx);
            check("ct_addr", 32'(bus.ct_addr), 32'(eng_addr(idx)));
            exp_rd.push_back('{idx: idx, dat: mem_f(eng_addr(idx))});
            @(negedge clk);
            r = exp_rd.pop_front();
            check("rdvalid", 32'(bus.eng_ct_rdvalid), 32'(1) << r.idx);
            check("rddata", 32'(bus.eng_ct_rddata), 32'(r.dat));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int launch, nst;
        rst_n             = 1'b0;
        bus.en            = 1'b0;
        bus.eng_rdy       = '1;
        bus.eng_key       = '0;
        bus.eng_key_valid = '0;
        bus.eng_ct_req    = '0;
        for (int i = 0; i < N; i++) bus.eng_ct_addr[i*8 +: 8] = eng_addr(i);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rdy", bus.rdy, 1);
        check("rst_key", 32'(bus.key), 0);
        check("rst_keyvalid", bus.key_valid, 0);
        check("rst_winner", 32'(bus.winner), 0);
        check("rst_start", 32'(bus.eng_start), 0);
        check("rst_gnt", 32'(bus.eng_ct_gnt), 0);
        check("rst_rdvalid", 32'(bus.eng_ct_rdvalid), 0);
        check("rst_ct_addr", 32'(bus.ct_addr), 0);
        rst_n = 1'b1;

        // Launch timing: all-ones start pulse exactly once, on the third cycle.
        start_search(launch, nst);
        check("launch_cycle", launch, 3);
        check("launch_count", nst, 1);
        check("run_rdy", bus.rdy, 0);

        // Everyone requests: strict rotation from pointer 0.
        bus.eng_ct_req = 4'hF;
        for (int k = 0; k < 8; k++) exp_gnt.push_back(k % N);
        run_grants(8);
        bus.eng_ct_req = '0;
        #1;
        check("idle_gnt", 32'(bus.eng_ct_gnt), 0);
        check("ct_addr_hold", 32'(bus.ct_addr), 32'(eng_addr(3)));
        @(negedge clk);
        check("idle_rdvalid", 32'(bus.eng_ct_rdvalid), 0);
        // Single requester is granted every cycle.
        bus.eng_ct_req = 4'b0100;
        for (int k = 0; k < 3; k++) exp_gnt.push_back(2);
        run_grants(3);
        bus.eng_ct_req = '0;

        // Engine 2 finds the key; engine 0 claims valid but is not rdy.
        bus.eng_key       = {24'h000000, 24'h001A2B, 24'h0D0D01, 24'hBEEF00};
        bus.eng_key_valid = 4'b0101;
        bus.eng_rdy       = 4'b0100;
        @(negedge clk);
        check("t2_key", 32'(bus.key), 32'h001A2B);
        check("t2_winner", 32'(bus.winner), 2);
        check("t2_keyvalid", bus.key_valid, 1);
        check("t2_rdy", bus.rdy, 1);
        bus.eng_key = '1;
        @(negedge clk);
        check("t2_key_hold", 32'(bus.key), 32'h001A2B);

        // Engines 1 and 3 together: engine 1 wins, later engine 3 result ignored.
        start_search(launch, nst);
        bus.eng_key       = {24'h0000B3, 24'h0000C2, 24'h0000B1, 24'h0000C0};
        bus.eng_rdy       = 4'b1010;
        bus.eng_key_valid = 4'b1010;
        @(negedge clk);
        check("t3_winner", 32'(bus.winner), 1);
        check("t3_key", 32'(bus.key), 32'h0000B1);
        bus.eng_rdy       = 4'hF;
        bus.eng_key_valid = 4'b1000;
        @(negedge clk);
        check("t3_winner_hold", 32'(bus.winner), 1);
        check("t3_key_hold", 32'(bus.key), 32'h0000B1);

        // Staggered finishes with no key: completion relies on the accumulated mask.
        start_search(launch, nst);
        bus.eng_rdy = 4'b0001;
        @(negedge clk);
        check("t4_busy0", bus.rdy, 0);
        bus.eng_rdy = 4'b0010;
        @(negedge clk);
        check("t4_busy1", bus.rdy, 0);
        bus.eng_rdy = 4'b0000;
        @(negedge clk);
        check("t4_busy2", bus.rdy, 0);
        bus.eng_rdy = 4'b1100;
        @(negedge clk);
        check("t4_rdy", bus.rdy, 1);
        check("t4_key", 32'(bus.key), 0);
        check("t4_keyvalid", bus.key_valid, 0);

        // Reset mid-RUN with requests pending; pointer was left at 3.
        start_search(launch, nst);
        bus.eng_ct_req = 4'hF;
        exp_gnt.push_back(3);
        run_grants(1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t6_rdy", bus.rdy, 1);
        check("t6_ct_addr", 32'(bus.ct_addr), 0);
        for (int k = 0; k < 3; k++) begin
            check("t6_gnt", 32'(bus.eng_ct_gnt), 0);
            check("t6_rdvalid", 32'(bus.eng_ct_rdvalid), 0);
            @(negedge clk);
        end
        // After reset the pointer restarts at engine 0.
        start_search(launch, nst);
        exp_gnt.push_back(0);
        run_grants(1);
        bus.eng_ct_req = '0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
